snake_game_ctrl: RTL and testbench

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_game_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game-flow controller for a snake game: key conditioning, game FSM, death blink,
// food placement from an LFSR, and score keeping.
module snake_game_ctrl #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int BLINK_CYC    = 12500000,
  parameter int DIE_BLINKS   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_start,
  input  logic       i_key_level,
  input  logic       i_hit_wall,
  input  logic       i_hit_body,
  input  logic [5:0] i_head_x,
  input  logic [5:0] i_head_y,
  output logic [1:0] o_game_status,
  output logic [1:0] o_fact_status,
  output logic       o_snake_display,
  output logic       o_add_cube,
  output logic [5:0] o_food_x,
  output logic [5:0] o_food_y,
  output logic       o_food_valid,
  output logic [7:0] o_score
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);
  localparam int TG_W = $clog2(2 * DIE_BLINKS + 1);

  typedef enum logic [1:0] {
    S_RESTART = 2'b00,
    S_PAUSE   = 2'b01,
    S_PLAY    = 2'b10,
    S_DIE     = 2'b11
  } state_t;

  logic [1:0] w_key_raw;
  logic [1:0] w_key_press;
  logic       w_start_press;
  logic       w_level_press;
  logic       w_collide;
  logic       w_blink_done;
  logic       w_eat;
  logic       w_die_entry;
  logic [5:0] w_cand_x;
  logic [5:0] w_cand_y;
  logic       w_cand_ok;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_fact;
  logic              r_display;
  logic [BL_W-1:0]   r_blink_cnt;
  logic [TG_W-1:0]   r_toggles;
  logic [15:0]       r_lfsr;
  logic [5:0]        r_food_x;
  logic [5:0]        r_food_y;
  logic              r_food_valid;
  logic [7:0]        r_score;

  assign w_key_raw = {i_key_level, i_key_start};

  // Keys idle high, so synchronizers and debounced levels reset to 1.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic            r_meta;
      logic            r_sync;
      logic            r_level;
      logic            r_press;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_meta  <= 1'b1;
          r_sync  <= 1'b1;
          r_level <= 1'b1;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_meta  <= w_key_raw[gi];
          r_sync  <= r_meta;
          r_press <= 1'b0;
          if (r_sync == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            r_cnt   <= '0;
            r_level <= r_sync;
            r_press <= ~r_sync;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_key_press[gi] = r_press;
    end
  endgenerate

  assign w_start_press = w_key_press[0];
  assign w_level_press = w_key_press[1];
  assign w_collide     = i_hit_wall | i_hit_body;
  assign w_blink_done  = (r_toggles == TG_W'(2 * DIE_BLINKS));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_RESTART;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESTART: if (w_start_press) w_state_next = S_PLAY;
      S_PLAY: begin
        if (w_collide)          w_state_next = S_DIE;
        else if (w_start_press) w_state_next = S_PAUSE;
      end
      S_PAUSE:   if (w_start_press) w_state_next = S_PLAY;
      S_DIE:     if (w_start_press && w_blink_done) w_state_next = S_RESTART;
      default:   w_state_next = S_RESTART;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fact <= 2'd0;
    end else if (r_state == S_RESTART && w_level_press) begin
      r_fact <= (r_fact == 2'd2) ? 2'd0 : r_fact + 2'd1;
    end
  end

  // The blank on entry counts as the first toggle, so the sequence ends visible.
  assign w_die_entry = (w_state_next == S_DIE) && (r_state != S_DIE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_display   <= 1'b1;
      r_blink_cnt <= '0;
      r_toggles   <= '0;
    end else if (w_die_entry) begin
      r_display   <= 1'b0;
      r_blink_cnt <= '0;
      r_toggles   <= TG_W'(1);
    end else if (r_state == S_DIE) begin
      if (!w_blink_done) begin
        if (r_blink_cnt == BL_W'(BLINK_CYC - 1)) begin
          r_blink_cnt <= '0;
          r_display   <= ~r_display;
          r_toggles   <= r_toggles + 1'b1;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end else begin
      r_display   <= 1'b1;
      r_blink_cnt <= '0;
      r_toggles   <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_cand_x  = r_lfsr[5:0];
  assign w_cand_y  = {1'b0, r_lfsr[12:8]};
  assign w_cand_ok = (w_cand_x >= 6'd1) && (w_cand_x <= 6'd38) &&
                     (w_cand_y >= 6'd1) && (w_cand_y <= 6'd28) &&
                     !((w_cand_x == i_head_x) && (w_cand_y == i_head_y));

  // A collision in the same cycle suppresses the eat entirely.
  assign w_eat = (r_state == S_PLAY) && r_food_valid && !w_collide &&
                 (i_head_x == r_food_x) && (i_head_y == r_food_y);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_food_x     <= 6'd20;
      r_food_y     <= 6'd15;
      r_food_valid <= 1'b1;
      r_score      <= 8'd0;
    end else if (w_state_next == S_RESTART) begin
      r_food_x     <= 6'd20;
      r_food_y     <= 6'd15;
      r_food_valid <= 1'b1;
      r_score      <= 8'd0;
    end else if (w_eat) begin
      r_food_valid <= 1'b0;
      r_score      <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    end else if (!r_food_valid && w_cand_ok) begin
      r_food_x     <= w_cand_x;
      r_food_y     <= w_cand_y;
      r_food_valid <= 1'b1;
    end
  end

  assign o_game_status   = r_state;
  assign o_fact_status   = r_fact;
  assign o_snake_display = r_display;
  assign o_add_cube      = w_eat;
  assign o_food_x        = r_food_x;
  assign o_food_y        = r_food_y;
  assign o_food_valid    = r_food_valid;
  assign o_score         = r_score;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed plus randomized bench for snake_game_ctrl against a transaction-level game model.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b1;
  logic       key_level = 1'b1;
  logic       hit_wall = 1'b0;
  logic       hit_body = 1'b0;
  logic [5:0] head_x = 6'd0;
  logic [5:0] head_y = 6'd0;
  logic [1:0] game_status, fact_status;
  logic       snake_display, add_cube, food_valid;
  logic [5:0] food_x, food_y;
  logic [7:0] score;

  int checks = 0;
  int failures = 0;
  int m_state = 0;
  int m_fact = 0;
  int m_score = 0;

  snake_game_ctrl #(.DEBOUNCE_CYC(4), .BLINK_CYC(8), .DIE_BLINKS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_start(key_start), .i_key_level(key_level),
    .i_hit_wall(hit_wall), .i_hit_body(hit_body), .i_head_x(head_x), .i_head_y(head_y),
    .o_game_status(game_status), .o_fact_status(fact_status),
    .o_snake_display(snake_display), .o_add_cube(add_cube),
    .o_food_x(food_x), .o_food_y(food_y), .o_food_valid(food_valid), .o_score(score)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string where);
    chk({where, "_status"}, game_status, m_state);
    chk({where, "_fact"}, fact_status, m_fact);
    chk({where, "_score"}, score, m_score);
  endtask

  task automatic chk_reset_values(input string where);
    chk({where, "_status"}, game_status, 0);
    chk({where, "_fact"}, fact_status, 0);
    chk({where, "_display"}, snake_display, 1);
    chk({where, "_add_cube"}, add_cube, 0);
    chk({where, "_food_x"}, food_x, 20);
    chk({where, "_food_y"}, food_y, 15);
    chk({where, "_food_valid"}, food_valid, 1);
    chk({where, "_score"}, score, 0);
  endtask

  // Game-rule model of one start press; DIE is only left once the blink has finished.
  task automatic model_start();
    case (m_state)
      0: m_state = 2;
      2: m_state = 1;
      1: m_state = 2;
      default: begin m_state = 0; m_score = 0; end
    endcase
  endtask

  task automatic press_start();
    key_start = 1'b0;
    repeat (10) tick();
    key_start = 1'b1;
    repeat (10) tick();
    model_start();
  endtask

  task automatic press_level();
    key_level = 1'b0;
    repeat (10) tick();
    key_level = 1'b1;
    repeat (10) tick();
    if (m_state == 0) m_fact = (m_fact + 1) % 3;
  endtask

  // Waits for a fresh food cell while the head sits on a random interior cell.
  task automatic wait_food();
    logic [5:0] hx, hy;
    int n;
    hx = 6'($urandom_range(1, 38));
    hy = 6'($urandom_range(1, 28));
    head_x = hx;
    head_y = hy;
    n = 0;
    while (!food_valid && n < 500) begin
      tick();
      n++;
    end
    chk("food_valid_wait", food_valid, 1);
    chk("food_cell_legal",
        (food_x >= 1 && food_x <= 38 && food_y >= 1 && food_y <= 28 &&
         !(food_x == hx && food_y == hy)), 1);
    head_x = 6'd0;
    head_y = 6'd0;
  endtask

  task automatic eat_once(input bit expect_eat);
    head_x = food_x;
    head_y = food_y;
    #1;
    chk("add_cube_on_food", add_cube, expect_eat);
    tick();
    head_x = 6'd0;
    head_y = 6'd0;
    #1;
    if (expect_eat && m_score < 255) m_score++;
    chk("add_cube_after", add_cube, 0);
    chk("score_after_eat", score, m_score);
    if (expect_eat) chk("food_invalid_after_eat", food_valid, 0);
  endtask

  initial begin
    int op;
    int exp_disp;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk_reset_values("reset");
    rst = 1'b0;
    tick();
    $display("step reset released status=%0d", game_status);

    // Short glitch on start: no event
    key_start = 1'b0;
    repeat (3) tick();
    key_start = 1'b1;
    repeat (10) tick();
    chk("short_press_status", game_status, 0);
    $display("step short start press status=%0d", game_status);

    // Four level presses in RESTART
    for (int i = 0; i < 4; i++) begin
      press_level();
      chk("level_cycle", fact_status, m_fact);
      $display("step level press %0d fact=%0d", i, fact_status);
    end

    press_start();
    check_model("start_to_play");
    $display("step start press status=%0d", game_status);

    press_level();
    check_model("level_in_play");
    $display("step level press in play fact=%0d", fact_status);

    // First eat at the restart food cell
    chk("food_initial_x", food_x, 20);
    chk("food_initial_y", food_y, 15);
    eat_once(1'b1);
    wait_food();
    $display("step first eat score=%0d food=(%0d,%0d)", score, food_x, food_y);

    // Pause, collision ignored while paused, resume
    press_start();
    check_model("pause");
    hit_wall = 1'b1;
    tick();
    hit_wall = 1'b0;
    tick();
    check_model("wall_in_pause");
    press_start();
    check_model("resume");
    $display("step pause/resume status=%0d", game_status);

    // Saturation of the score
    for (int i = 0; i < 256; i++) begin
      eat_once(1'b1);
      wait_food();
    end
    chk("score_saturated", score, 255);
    $display("step 256 eats score=%0d", score);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: press_start();
        1: press_level();
        2: begin
          if ($urandom_range(0, 1) == 1) hit_wall = 1'b1;
          else hit_body = 1'b1;
          tick();
          hit_wall = 1'b0;
          hit_body = 1'b0;
          if (m_state == 2) begin
            m_state = 3;
            repeat (40) tick();
          end
        end
        3: begin
          if (food_valid) eat_once(m_state == 2);
          wait_food();
        end
        default: repeat ($urandom_range(1, 5)) tick();
      endcase
      check_model("random");
      $display("step random op=%0d status=%0d fact=%0d score=%0d", op, game_status, fact_status, score);
    end

    // Collision with head on food, then death blink
    for (int i = 0; i < 3 && m_state != 2; i++) press_start();
    check_model("to_play_for_die");
    wait_food();
    m_score = score;
    head_x = food_x;
    head_y = food_y;
    hit_body = 1'b1;
    #1;
    chk("die_add_cube", add_cube, 0);
    tick();
    hit_body = 1'b0;
    head_x = 6'd0;
    head_y = 6'd0;
    m_state = 3;
    chk("die_status", game_status, 3);
    chk("die_score_kept", score, m_score);
    chk("die_display_t0", snake_display, 0);
    for (int t = 1; t <= 40; t++) begin
      if (t == 1) key_start = 1'b0;
      if (t == 12) key_start = 1'b1;
      tick();
      exp_disp = (t < 8) ? 0 : (t < 16) ? 1 : (t < 24) ? 0 : 1;
      if (t == 7 || t == 8 || t == 15 || t == 16 || t == 23 || t == 24 || t == 40)
        chk("die_blink", snake_display, exp_disp);
    end
    chk("die_early_start_ignored", game_status, 3);
    press_start();
    check_model("die_to_restart");
    chk("restart_display", snake_display, 1);
    chk("restart_food_valid", food_valid, 1);
    $display("step death blink done status=%0d score=%0d", game_status, score);

    // Asynchronous reset in the middle of a blink
    press_start();
    hit_wall = 1'b1;
    tick();
    hit_wall = 1'b0;
    m_state = 3;
    repeat (10) tick();
    chk("pre_reset_status", game_status, 3);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("mid_blink_reset");
    #3 rst = 1'b0;
    m_state = 0;
    m_fact = 0;
    m_score = 0;
    tick();
    check_model("after_reset");
    $display("step mid-blink reset status=%0d display=%0d", game_status, snake_display);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
